// File: rtl/spi_slv.sv
// SPI mode-0 responder: oversamples SCLK/SS_N/MOSI in the clk domain, returns each
// received frame on rx_* and shifts one staged tx word out on MISO per frame.
module spi_slv #(
  parameter int SPI_MAXLEN  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        SCLK,
  input  logic                        SS_N,
  input  logic                        MOSI,
  output logic                        MISO,
  output logic                        miso_oe,
  input  logic [SPI_MAXLEN-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_underrun,
  output logic [SPI_MAXLEN-1:0]       rx_data,
  output logic [$clog2(SPI_MAXLEN):0] rx_nbits,
  output logic                        rx_overflow,
  output logic                        rx_valid,
  output logic                        busy
);

  localparam int CW = $clog2(SPI_MAXLEN) + 1;
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(SPI_MAXLEN);
  localparam logic [SW-1:0] SETTLE  = SW'(SYNC_STAGES + 1);

  // ACTIVE owns bit 1 alone so busy and miso_oe come straight off a flop.
  typedef enum logic [1:0] {
    WAIT_DESEL = 2'b00,
    IDLE       = 2'b01,
    ACTIVE     = 2'b10
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_prev, ss_prev;
  logic [SW-1:0]          settle;
  logic [SPI_MAXLEN-1:0]  stage, tx_shift, rx_shift;
  logic                   staged, ovf;
  logic [CW-1:0]          cnt;

  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_rise   = ss_s & ~ss_prev;
  assign ss_fall   = ~ss_s & ss_prev;

  assign busy     = state[1];
  assign miso_oe  = state[1];
  assign tx_ready = ~staged;

  // Pin synchronizers plus one history flop each for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  // Frame FSM, shift registers, staging register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_DESEL;
      settle      <= '0;
      stage       <= '0;
      staged      <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      MISO        <= 1'b0;
      tx_underrun <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_nbits    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      MISO        <= (state == ACTIVE) ? tx_shift[SPI_MAXLEN-1] : 1'b0;
      if (settle != SETTLE) begin
        settle <= settle + SW'(1);
      end
      case (state)
        // The synchronizers reset to "deselected", so only trust SS_N once they
        // have refilled from the pin; otherwise a reset mid-frame would re-enter it.
        WAIT_DESEL: begin
          if (settle == SETTLE && ss_s) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (ss_fall) begin
            state    <= ACTIVE;
            rx_shift <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            if (staged) begin
              tx_shift <= stage;
              staged   <= 1'b0;
            end else begin
              tx_shift    <= '0;
              tx_underrun <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state <= IDLE;
            if (cnt != '0) begin
              rx_valid    <= 1'b1;
              rx_data     <= rx_shift;
              rx_nbits    <= cnt;
              rx_overflow <= ovf;
            end
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[SPI_MAXLEN-2:0], mosi_s};
            if (cnt == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (sclk_fall) begin
            tx_shift <= tx_shift << 1;
          end
        end
        default: state <= WAIT_DESEL;
      endcase
      // Only possible while empty, so it never collides with the load above.
      if (tx_valid && !staged) begin
        stage  <= tx_data;
        staged <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slv.sv
// Self-checking bench for spi_slv: a mode-0 master drives frames and results are
// compared with a frame-level model of what the responder must return.
module tb_spi_slv;

  localparam int H = 10;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset, SCLK, SS_N, MOSI, MISO, miso_oe;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, tx_underrun;
  logic [15:0] rx_data;
  logic [4:0]  rx_nbits;
  logic        rx_overflow, rx_valid, busy;

  int          n_cmp = 0, n_err = 0;
  int          rx_cnt = 0, ud_cnt = 0;
  logic [15:0] rx_d;
  logic [4:0]  rx_n;
  logic        rx_o;
  logic        have_staged = 1'b0;
  logic [15:0] staged_word = 16'h0;

  spi_slv #(.SPI_MAXLEN(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI),
    .MISO(MISO), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_nbits(rx_nbits), .rx_overflow(rx_overflow), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every rx_valid and tx_underrun pulse.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_d   <= rx_data;
      rx_n   <= rx_nbits;
      rx_o   <= rx_overflow;
    end
    if (tx_underrun) ud_cnt <= ud_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, 32'(MISO), 32'd0);
    check({tag, "_oe"}, 32'(miso_oe), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rxd"}, 32'(rx_data), 32'd0);
    check({tag, "_rxn"}, 32'(rx_nbits), 32'd0);
    check({tag, "_rxo"}, 32'(rx_overflow), 32'd0);
    check({tag, "_rxv"}, 32'(rx_valid), 32'd0);
    check({tag, "_rdy"}, 32'(tx_ready), 32'd1);
    check({tag, "_ud"}, 32'(tx_underrun), 32'd0);
  endtask

  task automatic stage(input logic [15:0] w);
    check("tx_ready_pre", 32'(tx_ready), 32'(!have_staged));
    tx_data  = w;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    check("tx_ready_post", 32'(tx_ready), 32'd0);
    have_staged = 1'b1;
    staged_word = w;
  endtask

  // One master frame of n bits of d (MSB first); optional reset before bit rst_bit,
  // optional staging of mid_w during the frame.
  task automatic frame(input int n, input logic [31:0] d, input int rst_bit,
                       input logic mid, input logic [15:0] mid_w);
    logic [31:0] w32, cap, exp_miso, exp_rx;
    int          m, rx0, ud0;
    logic        had, aborted;
    had = have_staged;
    w32 = had ? {16'h0, staged_word} : 32'h0;
    have_staged = 1'b0;
    rx0 = rx_cnt;
    ud0 = ud_cnt;
    cap = 32'h0;
    aborted = 1'b0;
    SS_N = 1'b0;
    wait_clk(H);
    for (int i = 0; i < n; i++) begin
      if (i == rst_bit) begin
        reset = 1'b1;
        wait_clk(2);
        check_reset_values("midrst");
        reset = 1'b0;
        have_staged = 1'b0;
        aborted = 1'b1;
        wait_clk(1);
      end
      MOSI = d[n-1-i];
      wait_clk(H);
      if (i == 0 && !aborted) begin
        check("busy_active", 32'(busy), 32'd1);
        check("oe_active", 32'(miso_oe), 32'd1);
      end
      cap  = {cap[30:0], MISO};
      SCLK = 1'b1;
      wait_clk(H);
      SCLK = 1'b0;
      if (mid && i == 2) stage(mid_w);
      wait_clk(H);
    end
    SS_N = 1'b1;
    wait_clk(H);
    if (aborted) begin
      check("rx_after_reset", 32'(rx_cnt - rx0), 32'd0);
    end else begin
      m        = (n > 16) ? 16 : n;
      exp_rx   = d & ((32'd1 << m) - 32'd1);
      exp_miso = (n <= 16) ? (w32 >> (16 - n)) : (w32 << (n - 16));
      check("rx_pulses", 32'(rx_cnt - rx0), 32'(n > 0));
      check("underrun", 32'(ud_cnt - ud0), 32'(!had));
      check("miso_word", cap, exp_miso);
      check("busy_idle", 32'(busy), 32'd0);
      if (n > 0) begin
        check("rx_data", 32'(rx_d), exp_rx);
        check("rx_nbits", 32'(rx_n), 32'(m));
        check("rx_ovf", 32'(rx_o), 32'(n > 16));
      end
    end
  endtask

  initial begin
    int          rx0, n;
    logic [31:0] d;
    reset = 1'b1; SCLK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
    tx_valid = 1'b0; tx_data = 16'h0;
    wait_clk(3);
    check_reset_values("rst");
    reset = 1'b0;
    wait_clk(6);

    stage(16'hA5C3);
    frame(16, 32'h1234, -1, 1'b0, 16'h0);
    stage(16'h9F31);
    frame(5, 32'h16, -1, 1'b0, 16'h0);
    stage(16'h5AA5);
    frame(20, 32'hABCDE, -1, 1'b0, 16'h0);

    frame(16, 32'h7E81, -1, 1'b1, 16'h00FF);
    check("staged_held", 32'(tx_ready), 32'd0);
    frame(16, 32'h0F0F, -1, 1'b0, 16'h0);

    frame(0, 32'h0, -1, 1'b0, 16'h0);
    rx0 = rx_cnt;
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'($urandom);
      SCLK = 1'b1;
      wait_clk(H);
      SCLK = 1'b0;
      wait_clk(H);
    end
    check("sclk_desel_rx", 32'(rx_cnt - rx0), 32'd0);
    check("sclk_desel_busy", 32'(busy), 32'd0);

    stage(16'hC0DE);
    frame(16, 32'h3C3C, 7, 1'b0, 16'h0);
    stage(16'h1357);
    frame(16, 32'hBEEF, -1, 1'b0, 16'h0);

    for (int k = 0; k < 10; k++) begin
      n = int'($urandom_range(20, 0));
      d = $urandom;
      if ($urandom_range(1, 0) == 1) stage(16'($urandom));
      frame(n, d, -1, 1'b0, 16'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
